// File: rtl/elevator_pkg.sv
// Shared types and constants for the elevator car controller.
package elevator_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MOVE   = 2'd1,
    ARRIVE = 2'd2,
    DOOR   = 2'd3
  } car_state_t;

  localparam int              FLOOR_W   = 2;
  localparam logic [FLOOR_W-1:0] TOP_FLOOR = 2'd3;
  localparam logic            DIR_UP    = 1'b1;
  localparam logic            DIR_DOWN  = 1'b0;

  // True when one floor of travel in dir stays inside 0..TOP_FLOOR.
  function automatic logic can_move(input logic [FLOOR_W-1:0] floor, input logic dir);
    logic ok_s;
    if (dir == DIR_UP) begin
      ok_s = (floor != TOP_FLOOR);
    end else begin
      ok_s = (floor != 2'd0);
    end
    return ok_s;
  endfunction

endpackage

// File: rtl/elev_timer.sv
// Loadable down-counter with a zero flag, shared by the car's timed states.
module elev_timer #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] count_r;

  // Load has priority; otherwise count down and park at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= '0;
    end else if (load) begin
      count_r <= load_val;
    end else if (en && (count_r != '0)) begin
      count_r <= count_r - ONE;
    end else begin
      count_r <= count_r;
    end
  end

  assign zero = (count_r == '0);

endmodule

// File: rtl/elevator_car_controller.sv
// Car-side motion/door FSM: consumes scheduler requests, reports floor, direction,
// arrival strobe and idle flag through registered outputs.
module elevator_car_controller
  import elevator_pkg::*;
#(
  parameter int TRAVEL_CYCLES = 16,
  parameter int DOOR_CYCLES   = 32,
  parameter int ACK_TIMEOUT   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               UDRequest,
  input  logic               OCRequest,
  input  logic               NoStopRequest,
  input  logic               DoneDelay,
  output logic [FLOOR_W-1:0] CurrentFloor,
  output logic               UDIn,
  output logic               Delay,
  output logic               Stop,
  output logic               DoorOpen,
  output logic               Moving
);

  localparam int MAX_TD = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
  localparam int MAX_C  = (MAX_TD > ACK_TIMEOUT) ? MAX_TD : ACK_TIMEOUT;
  localparam int TW     = $clog2(MAX_C);

  localparam logic [TW-1:0] TRAVEL_LD = TW'(TRAVEL_CYCLES - 1);
  localparam logic [TW-1:0] DOOR_LD   = TW'(DOOR_CYCLES - 1);
  localparam logic [TW-1:0] ACK_LD    = TW'(ACK_TIMEOUT - 1);

  car_state_t         state_r, state_nxt_s;
  logic [FLOOR_W-1:0] floor_nxt_s;
  logic               dir_nxt_s;
  logic               tmr_load_s, tmr_zero_s;
  logic [TW-1:0]      tmr_val_s;
  logic               stop_nxt_s, moving_nxt_s, delay_nxt_s, door_nxt_s;

  elev_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load_s),
    .en       (state_r != IDLE),
    .load_val (tmr_val_s),
    .zero     (tmr_zero_s)
  );

  // State, position and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      CurrentFloor <= 2'd0;
      UDIn         <= DIR_UP;
      Stop         <= 1'b1;
      Moving       <= 1'b0;
      Delay        <= 1'b0;
      DoorOpen     <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      CurrentFloor <= floor_nxt_s;
      UDIn         <= dir_nxt_s;
      Stop         <= stop_nxt_s;
      Moving       <= moving_nxt_s;
      Delay        <= delay_nxt_s;
      DoorOpen     <= door_nxt_s;
    end
  end

  // Next-state, position update and timer reload decisions.
  always_comb begin
    state_nxt_s = state_r;
    floor_nxt_s = CurrentFloor;
    dir_nxt_s   = UDIn;
    tmr_load_s  = 1'b0;
    tmr_val_s   = '0;
    case (state_r)
      IDLE: begin
        if (NoStopRequest) begin
          dir_nxt_s  = UDRequest;
          tmr_load_s = 1'b1;
          if (can_move(CurrentFloor, UDRequest)) begin
            state_nxt_s = MOVE;
            tmr_val_s   = TRAVEL_LD;
          end else begin
            state_nxt_s = ARRIVE;
            tmr_val_s   = ACK_LD;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      MOVE: begin
        if (tmr_zero_s) begin
          floor_nxt_s = (UDIn == DIR_UP) ? CurrentFloor + 2'd1 : CurrentFloor - 2'd1;
          state_nxt_s = ARRIVE;
          tmr_load_s  = 1'b1;
          tmr_val_s   = ACK_LD;
        end else begin
          state_nxt_s = MOVE;
        end
      end
      ARRIVE: begin
        if (DoneDelay) begin
          if (OCRequest) begin
            state_nxt_s = DOOR;
            tmr_load_s  = 1'b1;
            tmr_val_s   = DOOR_LD;
          end else begin
            dir_nxt_s = UDRequest;
            if (can_move(CurrentFloor, UDRequest)) begin
              state_nxt_s = MOVE;
              tmr_load_s  = 1'b1;
              tmr_val_s   = TRAVEL_LD;
            end else begin
              state_nxt_s = IDLE;
            end
          end
        end else if (tmr_zero_s) begin
          // Unacknowledged arrival: keep going the same way if possible.
          if (can_move(CurrentFloor, UDIn)) begin
            state_nxt_s = MOVE;
            tmr_load_s  = 1'b1;
            tmr_val_s   = TRAVEL_LD;
          end else begin
            state_nxt_s = IDLE;
          end
        end else begin
          state_nxt_s = ARRIVE;
        end
      end
      DOOR: begin
        if (tmr_zero_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DOOR;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // One-hot status decode of the upcoming state.
  always_comb begin
    stop_nxt_s   = 1'b0;
    moving_nxt_s = 1'b0;
    delay_nxt_s  = 1'b0;
    door_nxt_s   = 1'b0;
    case (state_nxt_s)
      IDLE:    stop_nxt_s   = 1'b1;
      MOVE:    moving_nxt_s = 1'b1;
      ARRIVE:  delay_nxt_s  = 1'b1;
      DOOR:    door_nxt_s   = 1'b1;
      default: stop_nxt_s   = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_elevator_car_controller.sv
// Self-checking bench: directed scenarios with literal expectations plus random
// traffic, all compared each cycle against a phase/elapsed-time car model.
module tb_elevator_car_controller;

  localparam int TC = 16;
  localparam int DC = 32;
  localparam int AC = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ud = 1'b0, oc = 1'b0, nsr = 1'b0, dd = 1'b0;
  logic [1:0] cur;
  logic       udin, dly, stp, dopen, mov;

  int n_checks = 0;
  int n_pass   = 0;
  int n_tmp;

  elevator_car_controller #(
    .TRAVEL_CYCLES (TC),
    .DOOR_CYCLES   (DC),
    .ACK_TIMEOUT   (AC)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .UDRequest     (ud),
    .OCRequest     (oc),
    .NoStopRequest (nsr),
    .DoneDelay     (dd),
    .CurrentFloor  (cur),
    .UDIn          (udin),
    .Delay         (dly),
    .Stop          (stp),
    .DoorOpen      (dopen),
    .Moving        (mov)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks = n_checks + 1;
    if (act == exp) n_pass = n_pass + 1;
    else $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
  endtask

  // Model: mode 0 idle, 1 travelling, 2 awaiting ack, 3 door; elapsed counts cycles in mode.
  int   m_mode, m_elapsed, m_floor;
  logic m_dir;

  function automatic bit can_go(input int f, input logic d);
    int t;
    t = d ? f + 1 : f - 1;
    return (t >= 0) && (t <= 3);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode <= 0; m_elapsed <= 0; m_floor <= 0; m_dir <= 1'b1;
    end else begin
      case (m_mode)
        0: if (nsr) begin
             m_dir <= ud; m_elapsed <= 1;
             m_mode <= can_go(m_floor, ud) ? 1 : 2;
           end
        1: if (m_elapsed == TC) begin
             m_floor <= m_dir ? m_floor + 1 : m_floor - 1;
             m_mode <= 2; m_elapsed <= 1;
           end else m_elapsed <= m_elapsed + 1;
        2: if (dd) begin
             m_elapsed <= 1;
             if (oc) m_mode <= 3;
             else begin
               m_dir <= ud;
               m_mode <= can_go(m_floor, ud) ? 1 : 0;
             end
           end else if (m_elapsed == AC) begin
             m_elapsed <= 1;
             m_mode <= can_go(m_floor, m_dir) ? 1 : 0;
           end else m_elapsed <= m_elapsed + 1;
        3: if (m_elapsed == DC) begin m_mode <= 0; m_elapsed <= 0; end
           else m_elapsed <= m_elapsed + 1;
        default: m_mode <= 0;
      endcase
    end
  end

  // Compare process: every cycle out of reset.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("model_floor",  int'(cur),   m_floor);
      chk("model_dir",    int'(udin),  int'(m_dir));
      chk("model_stop",   int'(stp),   (m_mode == 0) ? 1 : 0);
      chk("model_moving", int'(mov),   (m_mode == 1) ? 1 : 0);
      chk("model_delay",  int'(dly),   (m_mode == 2) ? 1 : 0);
      chk("model_door",   int'(dopen), (m_mode == 3) ? 1 : 0);
      chk("onehot", int'(stp) + int'(mov) + int'(dly) + int'(dopen), 1);
    end
  end

  function automatic logic pick(input int sel);
    case (sel)
      0: return dly;
      1: return stp;
      2: return dopen;
      default: return mov;
    endcase
  endfunction

  task automatic wait_high(input string nm, input int sel, input int budget);
    int i;
    i = 0;
    while (!pick(sel) && i < budget) begin
      @(negedge clk);
      i++;
    end
    if (!pick(sel)) chk({nm, "_timeout"}, 0, 1);
  endtask

  task automatic count_high(input int sel, input int budget, output int n);
    n = 0;
    while (pick(sel) && n < budget) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic pulse(input logic p_nsr, input logic p_dd, input logic p_oc, input logic p_ud);
    nsr = p_nsr; dd = p_dd; oc = p_oc; ud = p_ud;
    @(negedge clk);
    nsr = 1'b0; dd = 1'b0; oc = 1'b0;
  endtask

  task automatic check_reset_vals(input string nm);
    chk({nm, "_floor"}, int'(cur), 0);
    chk({nm, "_udin"},  int'(udin), 1);
    chk({nm, "_stop"},  int'(stp), 1);
    chk({nm, "_delay"}, int'(dly), 0);
    chk({nm, "_door"},  int'(dopen), 0);
    chk({nm, "_mov"},   int'(mov), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check_reset_vals("reset");

    // Up one floor from 0.
    pulse(1'b1, 1'b0, 1'b0, 1'b1);
    chk("start_moving", int'(mov), 1);
    chk("start_stop", int'(stp), 0);
    repeat (TC - 1) @(negedge clk);
    chk("pre_arrive_floor", int'(cur), 0);
    @(negedge clk);
    chk("arrive_floor1", int'(cur), 1);
    chk("arrive_delay", int'(dly), 1);

    // Door open at floor 1.
    pulse(1'b0, 1'b1, 1'b1, 1'b0);
    chk("door_open", int'(dopen), 1);
    count_high(2, 100, n_tmp);
    chk("door_dwell", n_tmp, DC);
    chk("door_then_stop", int'(stp), 1);
    chk("door_floor", int'(cur), 1);

    // Up to 2, continue to 3, then an infeasible up request goes idle.
    pulse(1'b1, 1'b0, 1'b0, 1'b1);
    wait_high("to2", 0, 40);
    chk("floor2", int'(cur), 2);
    pulse(1'b0, 1'b1, 1'b0, 1'b1);
    chk("continue_moving", int'(mov), 1);
    wait_high("to3", 0, 40);
    chk("floor3", int'(cur), 3);
    pulse(1'b0, 1'b1, 1'b0, 1'b1);
    chk("top_idle", int'(stp), 1);
    chk("top_no_wrap", int'(cur), 3);

    // Infeasible down request at floor 0 arrives in place.
    do_reset();
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    chk("direct_arrive", int'(dly), 1);
    chk("direct_floor", int'(cur), 0);
    chk("direct_not_moving", int'(mov), 0);
    count_high(0, 50, n_tmp);
    chk("direct_timeout_len", n_tmp, AC);
    chk("direct_then_idle", int'(stp), 1);

    // Unacknowledged arrival at floor 1 keeps going up.
    pulse(1'b1, 1'b0, 1'b0, 1'b1);
    wait_high("to1", 0, 40);
    chk("timeout_floor1", int'(cur), 1);
    count_high(0, 50, n_tmp);
    chk("timeout_len", n_tmp, AC);
    chk("timeout_moving", int'(mov), 1);

    // Asynchronous reset while moving from floor 2.
    wait_high("to2b", 0, 40);
    chk("floor2b", int'(cur), 2);
    pulse(1'b0, 1'b1, 1'b0, 1'b1);
    repeat (5) @(negedge clk);
    chk("mid_move", int'(mov), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals("async_rst");
    @(negedge clk);
    rst_n = 1'b1;

    // Random traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      nsr = ($urandom_range(0, 3) == 0);
      ud  = 1'($urandom_range(0, 1));
      dd  = ($urandom_range(0, 4) == 0);
      oc  = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 599) == 0) begin
        #1;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
      end
    end

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
